// File: rtl/warp_job_sequencer_if.sv
// warp_job_sequencer_if: job, engine-control and result channels of the warp job sequencer
interface warp_job_sequencer_if;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [3:0]  job_tag_i;
    logic [31:0] job_src_width_i;
    logic [31:0] job_src_height_i;
    logic [31:0] job_src_offset_i;
    logic [31:0] job_dst_width_i;
    logic [31:0] job_dst_height_i;
    logic [31:0] job_dst_offset_i;
    logic [31:0] src_width_o;
    logic [31:0] src_height_o;
    logic [31:0] src_offset_addr_o;
    logic [31:0] src_image_size_o;
    logic [31:0] dst_width_o;
    logic [31:0] dst_height_o;
    logic [31:0] dst_offset_addr_o;
    logic [31:0] dst_image_size_o;
    logic        start_o;
    logic        idle_i;
    logic [31:0] exit_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [3:0]  res_tag_o;
    logic [31:0] res_exit_o;
    logic        res_timeout_o;
    logic        busy_o;
    logic [15:0] jobs_done_o;

    modport slave (
        input  job_valid_i, job_tag_i, job_src_width_i, job_src_height_i, job_src_offset_i,
               job_dst_width_i, job_dst_height_i, job_dst_offset_i, idle_i, exit_i, res_ready_i,
        output job_ready_o, src_width_o, src_height_o, src_offset_addr_o, src_image_size_o,
               dst_width_o, dst_height_o, dst_offset_addr_o, dst_image_size_o, start_o,
               res_valid_o, res_tag_o, res_exit_o, res_timeout_o, busy_o, jobs_done_o
    );

    modport master (
        output job_valid_i, job_tag_i, job_src_width_i, job_src_height_i, job_src_offset_i,
               job_dst_width_i, job_dst_height_i, job_dst_offset_i, idle_i, exit_i, res_ready_i,
        input  job_ready_o, src_width_o, src_height_o, src_offset_addr_o, src_image_size_o,
               dst_width_o, dst_height_o, dst_offset_addr_o, dst_image_size_o, start_o,
               res_valid_o, res_tag_o, res_exit_o, res_timeout_o, busy_o, jobs_done_o
    );
endinterface

// File: rtl/warp_job_sequencer.sv
// warp_job_sequencer: queues warp job descriptors, programs and starts the engine, reports each job's result
module warp_job_sequencer #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] TIMEOUT = 32'd16777216
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    warp_job_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, RUN, RESP} state_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] src_w;
        logic [31:0] src_h;
        logic [31:0] src_off;
        logic [31:0] dst_w;
        logic [31:0] dst_h;
        logic [31:0] dst_off;
    } job_t;

    state_t        r_state, w_next;
    job_t          r_mem [DEPTH];
    job_t          r_job, w_in;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_next;
    logic          r_ready, r_timeout;
    logic [31:0]   r_src_size, r_dst_size, r_wd, r_exit, w_wd_inc;
    logic [15:0]   r_done;
    logic          w_push, w_pop, w_wd_hit, w_fin_ok, w_fin_to;

    assign w_push       = bus.job_valid_i && r_ready;
    assign w_pop        = (r_state == IDLE) && (r_count != '0) && bus.idle_i;
    assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_wd_inc     = r_wd + 32'd1;
    assign w_wd_hit     = w_wd_inc >= TIMEOUT;
    assign w_in         = '{tag: bus.job_tag_i, src_w: bus.job_src_width_i, src_h: bus.job_src_height_i,
                            src_off: bus.job_src_offset_i, dst_w: bus.job_dst_width_i,
                            dst_h: bus.job_dst_height_i, dst_off: bus.job_dst_offset_i};

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in;
    end

    // Ready is registered from the post-update occupancy, so a full FIFO refuses a push even while popping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_ready <= w_count_next != (AW+1)'(DEPTH);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_fin_ok = 1'b0;
        w_fin_to = 1'b0;
        case (r_state)
            IDLE:      w_next = w_pop ? LOAD : IDLE;
            LOAD:      w_next = START;
            START:     w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                w_fin_to = bus.idle_i && w_wd_hit;
                w_next   = !bus.idle_i ? RUN : w_fin_to ? RESP : WAIT_BUSY;
            end
            RUN: begin
                w_fin_ok = bus.idle_i;
                w_fin_to = !bus.idle_i && w_wd_hit;
                w_next   = (w_fin_ok || w_fin_to) ? RESP : RUN;
            end
            RESP:      w_next = bus.res_ready_i ? IDLE : RESP;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_job      <= '0;
            r_src_size <= '0;
            r_dst_size <= '0;
            r_wd       <= '0;
            r_exit     <= '0;
            r_timeout  <= 1'b0;
            r_done     <= '0;
        end else begin
            if (w_pop) r_job <= r_mem[r_rd_ptr];
            if (r_state == LOAD) begin
                r_src_size <= r_job.src_w * r_job.src_h;
                r_dst_size <= r_job.dst_w * r_job.dst_h;
            end
            if (r_state == START) r_wd <= '0;
            else if (r_state == WAIT_BUSY || r_state == RUN) r_wd <= w_wd_inc;
            if (w_fin_ok) begin
                r_exit    <= bus.exit_i;
                r_timeout <= 1'b0;
            end else if (w_fin_to) begin
                r_exit    <= '1;
                r_timeout <= 1'b1;
            end
            if (r_state == RESP && bus.res_ready_i) r_done <= r_done + 16'd1;
        end
    end

    assign bus.job_ready_o       = r_ready;
    assign bus.src_width_o       = r_job.src_w;
    assign bus.src_height_o      = r_job.src_h;
    assign bus.src_offset_addr_o = r_job.src_off;
    assign bus.src_image_size_o  = r_src_size;
    assign bus.dst_width_o       = r_job.dst_w;
    assign bus.dst_height_o      = r_job.dst_h;
    assign bus.dst_offset_addr_o = r_job.dst_off;
    assign bus.dst_image_size_o  = r_dst_size;
    assign bus.start_o           = r_state == START;
    assign bus.res_valid_o       = r_state == RESP;
    assign bus.res_tag_o         = r_job.tag;
    assign bus.res_exit_o        = r_exit;
    assign bus.res_timeout_o     = r_timeout;
    assign bus.busy_o            = r_state != IDLE;
    assign bus.jobs_done_o       = r_done;
endmodule

// File: tb/tb_warp_job_sequencer.sv
// tb_warp_job_sequencer: scoreboard bench with a behavioural engine model for the warp job sequencer
module tb_warp_job_sequencer;
    typedef logic [36:0] res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0, failures = 0, cyc = 0, last_acc = 0;
    res_t        sb[$];
    int          eng_busy = 50;
    bit          eng_hang = 0, eng_stall = 0, eng_off = 0;
    logic [31:0] eng_exit = '0;

    warp_job_sequencer_if bus();
    warp_job_sequencer #(.DEPTH(4), .TIMEOUT(32'd100)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: goes busy one cycle after seeing start, stays busy eng_busy cycles (or while hung).
    initial begin : engine
        bus.idle_i = 1'b1;
        bus.exit_i = '0;
        forever begin
            @(negedge clk);
            if (bus.start_o) begin
                @(negedge clk);
                bus.idle_i = 1'b0;
                repeat (eng_busy) @(negedge clk);
                while (eng_hang) @(negedge clk);
                bus.exit_i = eng_off ? bus.src_offset_addr_o : eng_exit;
                bus.idle_i = 1'b1;
            end else bus.idle_i = !eng_stall;
        end
    end

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result got tag=%0d exit=%h", bus.res_tag_o, bus.res_exit_o);
                end else begin
                    e = sb.pop_front();
                    if ({bus.res_tag_o, bus.res_exit_o, bus.res_timeout_o} !== e) begin
                        failures++;
                        $display("FAIL result got tag=%0d exit=%h to=%0d exp tag=%0d exit=%h to=%0d",
                                 bus.res_tag_o, bus.res_exit_o, bus.res_timeout_o, e[36:33], e[32:1], e[0]);
                    end
                end
            end
        end
    end

    function automatic bit outs_zero();
        return !(|{bus.start_o, bus.res_valid_o, bus.res_timeout_o, bus.busy_o, bus.jobs_done_o,
                   bus.res_tag_o, bus.res_exit_o, bus.src_width_o, bus.src_height_o, bus.src_offset_addr_o,
                   bus.src_image_size_o, bus.dst_width_o, bus.dst_height_o, bus.dst_offset_addr_o,
                   bus.dst_image_size_o});
    endfunction

    task automatic push_job(input logic [3:0] tag, input logic [31:0] sw, sh, so, dw, dh, doff, input res_t exp);
        int n;
        bus.job_valid_i = 1'b1;
        bus.job_tag_i = tag;
        bus.job_src_width_i = sw;
        bus.job_src_height_i = sh;
        bus.job_src_offset_i = so;
        bus.job_dst_width_i = dw;
        bus.job_dst_height_i = dh;
        bus.job_dst_offset_i = doff;
        for (n = 0; n < 400 && !bus.job_ready_o; n++) @(negedge clk);
        checks++;
        if (!bus.job_ready_o) begin
            failures++;
            $display("FAIL push_accept tag=%0d got ready=0 exp ready=1", tag);
        end else begin
            last_acc = cyc;
            sb.push_back(exp);
        end
        @(negedge clk);
        bus.job_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.job_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.job_ready_o); end
        checks++;
        if (!outs_zero()) begin failures++; $display("FAIL reset_outputs got nonzero exp all zero"); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        eng_busy = 50; eng_off = 0; eng_exit = '0; bus.res_ready_i = 1'b1;
        push_job(4'd3, 32'd640, 32'd480, 32'h1000, 32'd320, 32'd240, 32'h8000, {4'd3, 32'd0, 1'b0});
        for (n = 0; n < 20 && !bus.start_o; n++) @(negedge clk);
        checks++;
        if (!bus.start_o || cyc - last_acc != 3) begin
            failures++; $display("FAIL single_latency got=%0d exp=3 start=%b", cyc - last_acc, bus.start_o);
        end
        checks++;
        if (bus.src_image_size_o !== 32'd307200) begin failures++; $display("FAIL single_src_size got=%0d exp=307200", bus.src_image_size_o); end
        checks++;
        if (bus.dst_image_size_o !== 32'd76800) begin failures++; $display("FAIL single_dst_size got=%0d exp=76800", bus.dst_image_size_o); end
        checks++;
        if ({bus.src_width_o, bus.src_height_o, bus.src_offset_addr_o, bus.dst_width_o, bus.dst_height_o, bus.dst_offset_addr_o}
            !== {32'd640, 32'd480, 32'h1000, 32'd320, 32'd240, 32'h8000}) begin
            failures++; $display("FAIL single_config got w=%0d h=%0d off=%h exp w=640 h=480 off=1000", bus.src_width_o, bus.src_height_o, bus.src_offset_addr_o);
        end
        @(negedge clk);
        checks++;
        if (bus.start_o !== 1'b0) begin failures++; $display("FAIL single_pulse_width got start=%b exp=0", bus.start_o); end
        for (n = 0; n < 200 && (sb.size() != 0 || bus.busy_o); n++) @(negedge clk);
        checks++;
        if (bus.jobs_done_o !== 16'd1) begin failures++; $display("FAIL single_done got=%0d exp=1", bus.jobs_done_o); end
    endtask

    task automatic test_back_to_back;
        int n, acc0;
        logic [15:0] d0;
        logic [31:0] off;
        eng_stall = 1; eng_busy = 5; eng_off = 1; bus.res_ready_i = 1'b1;
        d0 = bus.jobs_done_o;
        repeat (2) @(negedge clk);
        acc0 = cyc;
        for (int t = 0; t < 4; t++) begin
            off = 32'h1000_0000 + 32'(t * 256);
            push_job(4'(t), 32'(16 + t), 32'd8, off, 32'd4, 32'd4, 32'd0, {4'(t), off, 1'b0});
        end
        checks++;
        if (last_acc - acc0 != 3) begin failures++; $display("FAIL b2b_consecutive got=%0d exp=3", last_acc - acc0); end
        checks++;
        if (bus.job_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", bus.job_ready_o); end
        fork
            push_job(4'd4, 32'd20, 32'd8, 32'h1000_0400, 32'd4, 32'd4, 32'd0, {4'd4, 32'h1000_0400, 1'b0});
            begin
                repeat (5) @(negedge clk);
                checks++;
                if (bus.job_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                    failures++; $display("FAIL b2b_stalled got ready=%b busy=%b exp 0 0", bus.job_ready_o, bus.busy_o);
                end
                eng_stall = 0;
            end
        join
        for (n = 0; n < 500 && (sb.size() != 0 || bus.busy_o); n++) @(negedge clk);
        checks++;
        if (bus.jobs_done_o !== d0 + 16'd5) begin failures++; $display("FAIL b2b_done got=%0d exp=%0d", bus.jobs_done_o, d0 + 16'd5); end
    endtask

    task automatic test_truncate;
        int n;
        eng_off = 0; eng_exit = 32'h77; eng_busy = 2; bus.res_ready_i = 1'b1;
        push_job(4'd11, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, {4'd11, 32'h77, 1'b0});
        for (n = 0; n < 20 && !bus.start_o; n++) @(negedge clk);
        checks++;
        if (bus.src_image_size_o !== 32'h0001_0000) begin failures++; $display("FAIL trunc_src got=%h exp=00010000", bus.src_image_size_o); end
        checks++;
        if (bus.dst_image_size_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL trunc_dst got=%h exp=fffffffe", bus.dst_image_size_o); end
        for (n = 0; n < 100 && (sb.size() != 0 || bus.busy_o); n++) @(negedge clk);
    endtask

    task automatic test_resp_hold;
        int n;
        logic [15:0] d0;
        eng_off = 1; eng_busy = 4; bus.res_ready_i = 1'b0;
        d0 = bus.jobs_done_o;
        push_job(4'd9, 32'd2, 32'd2, 32'h9009_0000, 32'd2, 32'd2, 32'd0, {4'd9, 32'h9009_0000, 1'b0});
        push_job(4'd10, 32'd3, 32'd3, 32'hA00A_0000, 32'd3, 32'd3, 32'd0, {4'd10, 32'hA00A_0000, 1'b0});
        for (n = 0; n < 100 && !bus.res_valid_o; n++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({bus.res_valid_o, bus.res_tag_o, bus.res_exit_o, bus.res_timeout_o, bus.start_o} !== {1'b1, 4'd9, 32'h9009_0000, 1'b0, 1'b0}) begin
                failures++; $display("FAIL hold_stable cycle=%0d got v=%b tag=%0d exit=%h start=%b exp v=1 tag=9 exit=90090000 start=0",
                                     i, bus.res_valid_o, bus.res_tag_o, bus.res_exit_o, bus.start_o);
            end
            @(negedge clk);
        end
        bus.res_ready_i = 1'b1;
        for (n = 0; n < 200 && (sb.size() != 0 || bus.busy_o); n++) @(negedge clk);
        checks++;
        if (bus.jobs_done_o !== d0 + 16'd2) begin failures++; $display("FAIL hold_done got=%0d exp=%0d", bus.jobs_done_o, d0 + 16'd2); end
    endtask

    task automatic test_timeout;
        int n, s;
        bit seen;
        logic [15:0] d0;
        eng_off = 1; eng_busy = 3; eng_hang = 1; bus.res_ready_i = 1'b1;
        d0 = bus.jobs_done_o;
        push_job(4'd6, 32'd5, 32'd5, 32'h6000_0006, 32'd5, 32'd5, 32'd0, {4'd6, 32'hFFFF_FFFF, 1'b1});
        push_job(4'd7, 32'd6, 32'd6, 32'h7000_0007, 32'd6, 32'd6, 32'd0, {4'd7, 32'h7000_0007, 1'b0});
        for (n = 0; n < 20 && !bus.start_o; n++) @(negedge clk);
        s = cyc;
        @(negedge clk);
        for (n = 0; n < 200 && !bus.res_valid_o; n++) @(negedge clk);
        checks++;
        if (!bus.res_valid_o || cyc - s != 101) begin failures++; $display("FAIL timeout_latency got=%0d exp=101", cyc - s); end
        checks++;
        if ({bus.res_exit_o, bus.res_timeout_o} !== {32'hFFFF_FFFF, 1'b1}) begin
            failures++; $display("FAIL timeout_flags got exit=%h to=%b exp exit=ffffffff to=1", bus.res_exit_o, bus.res_timeout_o);
        end
        seen = 0;
        repeat (30) begin @(negedge clk); seen |= bus.start_o; end
        checks++;
        if (seen || bus.busy_o !== 1'b0) begin failures++; $display("FAIL timeout_no_restart got start=%b busy=%b exp 0 0", seen, bus.busy_o); end
        eng_hang = 0;
        for (n = 0; n < 300 && (sb.size() != 0 || bus.busy_o); n++) @(negedge clk);
        checks++;
        if (bus.jobs_done_o !== d0 + 16'd2) begin failures++; $display("FAIL timeout_done got=%0d exp=%0d", bus.jobs_done_o, d0 + 16'd2); end
    endtask

    task automatic test_reset_mid;
        int n;
        bit seen;
        eng_off = 1; eng_busy = 40; bus.res_ready_i = 1'b1;
        push_job(4'd12, 32'd7, 32'd7, 32'hC000_000C, 32'd7, 32'd7, 32'd0, {4'd12, 32'hC000_000C, 1'b0});
        push_job(4'd13, 32'd8, 32'd8, 32'hD000_000D, 32'd8, 32'd8, 32'd0, {4'd13, 32'hD000_000D, 1'b0});
        for (n = 0; n < 20 && !bus.start_o; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL midrst_running got busy=%b exp=1", bus.busy_o); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.job_ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus.job_ready_o); end
        checks++;
        if (!outs_zero()) begin failures++; $display("FAIL midrst_outputs got nonzero exp all zero"); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin @(negedge clk); seen |= bus.start_o | bus.res_valid_o; end
        checks++;
        if (seen || bus.jobs_done_o !== 16'd0) begin
            failures++; $display("FAIL midrst_quiet got activity=%b done=%0d exp 0 0", seen, bus.jobs_done_o);
        end
    endtask

    initial begin
        bus.job_valid_i = 1'b0;
        bus.job_tag_i = '0;
        bus.job_src_width_i = '0;
        bus.job_src_height_i = '0;
        bus.job_src_offset_i = '0;
        bus.job_dst_width_i = '0;
        bus.job_dst_height_i = '0;
        bus.job_dst_offset_i = '0;
        bus.res_ready_i = 1'b0;
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_truncate;
        test_resp_hold;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/warp_job_sequencer.md
Name: warp_job_sequencer

Overview:
- Front-end controller for the CVA6-based image-warp engine.
- Queues image-warp job descriptors from a host-side requester in a small FIFO.
- For each job: programs the engine's src/dst geometry registers (including computed image sizes), pulses start, waits for the run to complete, then returns the exit code and job tag on a result channel.
- Includes a per-job watchdog timeout and a completed-job counter.

Parameters:
- DEPTH, 4: job FIFO entries; power of two, minimum 2.
- TIMEOUT, 32'd16777216: max cycles from start pulse to idle reassertion before the job is flagged as timed out.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- job_valid_i  in  1  job descriptor valid
- job_ready_o  out  1  FIFO can accept a job
- job_tag_i  in  4  requester tag
- job_src_width_i  in  32  source width
- job_src_height_i  in  32  source height
- job_src_offset_i  in  32  source offset address
- job_dst_width_i  in  32  destination width
- job_dst_height_i  in  32  destination height
- job_dst_offset_i  in  32  destination offset address
- src_width_o, src_height_o, src_offset_addr_o, src_image_size_o  out  32 each  engine source configuration
- dst_width_o, dst_height_o, dst_offset_addr_o, dst_image_size_o  out  32 each  engine destination configuration
- start_o  out  1  engine start pulse
- idle_i  in  1  engine idle
- exit_i  in  32  engine exit code
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_tag_o  out  4  tag of completed job
- res_exit_o  out  32  captured exit code
- res_timeout_o  out  1  job hit watchdog
- busy_o  out  1  FSM not in IDLE
- jobs_done_o  out  16  completed-result handshakes, wraps

Behaviour:
- Reset (async, rst_ni low): all outputs 0, except job_ready_o = 1. FIFO is emptied; FSM goes to IDLE; counters are cleared. A reset mid-job abandons the job silently (no result is produced).
- FIFO push: when job_valid_i && job_ready_o. job_ready_o = !full, registered.
  - When full, job_ready_o = 0 even if a pop occurs in the same cycle; the push is not taken.
  - No pop occurs while empty.
- FSM states:
  - IDLE: if FIFO non-empty && idle_i, pop the head into the descriptor registers and go to LOAD.
  - LOAD: register src_image_size = src_width*src_height and dst_image_size = dst_width*dst_height. Each is a 32x32 multiply truncated to the low 32 bits. Go to START.
  - START: start_o = 1 for exactly this one cycle; clear the watchdog. Go to WAIT_BUSY.
  - WAIT_BUSY: when idle_i == 0, go to RUN.
  - RUN: when idle_i == 1, capture exit_i into res_exit_o, set res_timeout_o = 0, go to RESP.
  - Watchdog: in WAIT_BUSY and RUN it increments every cycle. When it reaches TIMEOUT: res_exit_o = 32'hFFFF_FFFF, res_timeout_o = 1, go to RESP.
  - RESP: res_valid_o = 1; tag and exit are held stable until res_ready_i. On handshake, jobs_done_o increments (16-bit wrap) and the FSM returns to IDLE.
- Config outputs (src_*/dst_*) update on the IDLE->LOAD pop; image sizes update in LOAD. All are held constant until the next pop.
- Latency with FIFO empty, FSM in IDLE and idle_i = 1:
  - Job accepted at cycle N.
  - Pop occurs at N+1.
  - start_o is high at N+3, with all configuration outputs already valid.
- After a timeout, the next job waits in IDLE until idle_i returns to 1.
- busy_o = (state != IDLE).

Test Plan:
- Single job (src 640x480, dst 320x240, tag 3); engine drops idle 2 cycles after start, stays busy 50 cycles, exit_i = 0 -> start_o high exactly 1 cycle, 3 cycles after acceptance; src_image_size_o = 307200; dst_image_size_o = 76800; res_tag_o = 3, res_exit_o = 0, res_timeout_o = 0; jobs_done_o = 1.
- Push 5 jobs back-to-back with engine stalled busy -> job_ready_o drops after 4 accepted; jobs complete in order with tags 0..4; jobs_done_o = 5.
- TIMEOUT = 100, engine never reasserts idle -> RESP at start+101; res_exit_o = FFFF_FFFF, res_timeout_o = 1; next queued job not started until idle_i = 1.
- res_ready_i held low for 20 cycles in RESP -> res_valid_o, res_tag_o, res_exit_o stable; no new start_o issued.
- Width 0x0001_0000 x height 0x0001_0001 -> src_image_size_o = 0x0001_0000 (truncated).
- rst_ni asserted during RUN -> all outputs 0 (job_ready_o = 1); FIFO empty; no result emitted after release.
